line_sum3_stream: RTL

//  Streaming 3-row vertical window operator for a raster matrix received one

---
 rtl/line_sum3_stream_if.sv | 28 ++
 rtl/line_sum3_stream.sv | 128 ++++++++++++
 2 files changed

// File: rtl/line_sum3_stream_if.sv
// rtl/line_sum3_stream_if.sv - element-in / result-out bundle for line_sum3_stream
// The source side drives pi_*/mode; the operator drives the po_* result fields.
interface line_sum3_stream_if #(
  parameter int DATA_W   = 8,
  parameter int NUM_ROWS = 50
);
  localparam int OUT_W = DATA_W + 2;
  localparam int ROW_W = $clog2(NUM_ROWS);

  logic              pi_flag;
  logic              pi_sof;
  logic [DATA_W-1:0] pi_data;
  logic              mode;
  logic              po_flag;
  logic [OUT_W-1:0]  po_data;
  logic              po_last;
  logic [ROW_W-1:0]  po_row;

  modport master (
    output pi_flag, pi_sof, pi_data, mode,
    input  po_flag, po_data, po_last, po_row
  );

  modport slave (
    input  pi_flag, pi_sof, pi_data, mode,
    output po_flag, po_data, po_last, po_row
  );
endinterface

// File: rtl/line_sum3_stream.sv
// rtl/line_sum3_stream.sv - streaming 3-row vertical SUM/MAX window over a raster frame
// Two line buffers hold rows r-1 and r-2; each accepted element yields a result two cycles later from row 2 on.
module line_sum3_stream #(
  parameter int DATA_W   = 8,
  parameter int ROW_LEN  = 50,
  parameter int NUM_ROWS = 50
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  line_sum3_stream_if.slave  bus
);
  localparam int COL_W = $clog2(ROW_LEN);
  localparam int ROW_W = $clog2(NUM_ROWS);
  localparam int OUT_W = DATA_W + 2;

  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [DATA_W-1:0] r_lb1 [ROW_LEN];
  logic [DATA_W-1:0] r_lb2 [ROW_LEN];

  logic [DATA_W-1:0] r_s1_a;
  logic [DATA_W-1:0] r_s1_b;
  logic [DATA_W-1:0] r_s1_x;
  logic              r_s1_mode;
  logic              r_s1_last;
  logic [ROW_W-1:0]  r_s1_row;
  logic              r_s1_v;

  logic              r_po_flag;
  logic [OUT_W-1:0]  r_po_data;
  logic              r_po_last;
  logic [ROW_W-1:0]  r_po_row;

  logic [COL_W-1:0]  w_col;
  logic [ROW_W-1:0]  w_row;
  logic [COL_W-1:0]  w_col_nxt;
  logic [ROW_W-1:0]  w_row_nxt;
  logic              w_col_end;
  logic              w_row_end;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;
  logic [OUT_W-1:0]  w_sum;
  logic [DATA_W-1:0] w_max;
  logic [OUT_W-1:0]  w_res;

  // A flagged sof forces this element to (0,0) whatever the counters say.
  always_comb begin
    w_col     = bus.pi_sof ? '0 : r_col;
    w_row     = bus.pi_sof ? '0 : r_row;
    w_col_end = (w_col == COL_W'(ROW_LEN - 1));
    w_row_end = (w_row == ROW_W'(NUM_ROWS - 1));
    w_col_nxt = w_col_end ? '0 : w_col + 1'b1;
    w_row_nxt = w_row;
    if (w_col_end) begin
      w_row_nxt = w_row_end ? '0 : w_row + 1'b1;
    end
    w_rd_a = r_lb2[w_col];
    w_rd_b = r_lb1[w_col];
  end

  always_ff @(posedge sys_clk) begin
    if (bus.pi_flag) begin
      r_lb2[w_col] <= w_rd_b;
      r_lb1[w_col] <= bus.pi_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_col     <= '0;
      r_row     <= '0;
      r_s1_a    <= '0;
      r_s1_b    <= '0;
      r_s1_x    <= '0;
      r_s1_mode <= 1'b0;
      r_s1_last <= 1'b0;
      r_s1_row  <= '0;
      r_s1_v    <= 1'b0;
    end else begin
      r_s1_v <= 1'b0;
      if (bus.pi_flag) begin
        r_col     <= w_col_nxt;
        r_row     <= w_row_nxt;
        r_s1_a    <= w_rd_a;
        r_s1_b    <= w_rd_b;
        r_s1_x    <= bus.pi_data;
        r_s1_mode <= bus.mode;
        r_s1_last <= w_row_end && w_col_end;
        r_s1_row  <= w_row;
        r_s1_v    <= (w_row >= ROW_W'(2));
      end
    end
  end

  // Zero-extended adds keep the full 3*(2^DATA_W-1) range without wrap.
  always_comb begin
    w_sum = {2'b00, r_s1_a} + {2'b00, r_s1_b} + {2'b00, r_s1_x};
    w_max = r_s1_a;
    if (r_s1_b > w_max) begin
      w_max = r_s1_b;
    end
    if (r_s1_x > w_max) begin
      w_max = r_s1_x;
    end
    w_res = r_s1_mode ? {2'b00, w_max} : w_sum;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_po_flag <= 1'b0;
      r_po_data <= '0;
      r_po_last <= 1'b0;
      r_po_row  <= '0;
    end else begin
      r_po_flag <= r_s1_v;
      r_po_last <= r_s1_v && r_s1_last;
      if (r_s1_v) begin
        r_po_data <= w_res;
        r_po_row  <= r_s1_row;
      end
    end
  end

  assign bus.po_flag = r_po_flag;
  assign bus.po_data = r_po_data;
  assign bus.po_last = r_po_last;
  assign bus.po_row  = r_po_row;
endmodule
